// File: rtl/ext_slow_mem_arbiter.sv
// Round-robin arbiter sharing one slow OBI memory between NMASTER masters.
// One transaction in flight; out-of-window accesses get an error response.
module ext_slow_mem_arbiter #(
   parameter int unsigned NMASTER    = 2,
   // EXT_SLAVE_START_ADDRESS of core_v_mini_mcu_pkg
   parameter logic [31:0] START_ADDR = 32'hF000_0000,
   parameter logic [31:0] SIZE       = 32'h200,
   parameter logic [31:0] ERR_RDATA  = 32'hBADCAB1E
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NMASTER-1:0]     m_req_i,
   output logic [NMASTER-1:0]     m_gnt_o,
   input  logic [NMASTER*32-1:0]  m_addr_i,
   input  logic [NMASTER-1:0]     m_we_i,
   input  logic [NMASTER*4-1:0]   m_be_i,
   input  logic [NMASTER*32-1:0]  m_wdata_i,
   output logic [NMASTER-1:0]     m_rvalid_o,
   output logic [NMASTER*32-1:0]  m_rdata_o,
   output logic                   s_req_o,
   input  logic                   s_gnt_i,
   output logic [31:0]            s_addr_o,
   output logic                   s_we_o,
   output logic [3:0]             s_be_o,
   output logic [31:0]            s_wdata_o,
   input  logic                   s_rvalid_i,
   input  logic [31:0]            s_rdata_i,
   output logic                   busy_o,
   output logic                   err_o
);

   localparam int unsigned IW = $clog2(NMASTER);
   localparam int unsigned SW = IW + 1;
   localparam logic [32:0] LO = {1'b0, START_ADDR};
   localparam logic [32:0] HI = {1'b0, START_ADDR} + {1'b0, SIZE};

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      ERR_RESP
   } state_t;

   state_t state_q, state_d;
   logic [IW-1:0] win_q, win_d;
   logic [IW-1:0] rr_q, rr_d;
   logic [IW-1:0] pick;
   logic [IW-1:0] nxt_ptr;
   logic [SW-1:0] sum;
   logic          found;
   logic          in_win;
   logic          gnt;
   logic          rv;
   logic [31:0]   rdata;

   logic [31:0] addr_a  [NMASTER];
   logic [31:0] wdata_a [NMASTER];
   logic [3:0]  be_a    [NMASTER];

   for (genvar g = 0; g < NMASTER; g++) begin : g_unpack
      assign addr_a[g]  = m_addr_i[g*32 +: 32];
      assign wdata_a[g] = m_wdata_i[g*32 +: 32];
      assign be_a[g]    = m_be_i[g*4 +: 4];
   end

   // 33-bit compare keeps a window ending at 2^32 from wrapping
   assign in_win = ({1'b0, addr_a[win_q]} >= LO) &&
                   ({1'b0, addr_a[win_q]} < HI);

   assign nxt_ptr = (win_q == IW'(NMASTER - 1)) ? '0 : win_q + 1'b1;
   assign busy_o  = (state_q != IDLE);

   always_comb begin
      pick  = '0;
      found = 1'b0;
      sum   = '0;
      for (int i = 0; i < NMASTER; i++) begin
         sum = {1'b0, rr_q} + SW'(i);
         if (sum >= SW'(NMASTER)) sum = sum - SW'(NMASTER);
         if (!found && m_req_i[sum[IW-1:0]]) begin
            found = 1'b1;
            pick  = sum[IW-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         win_q   <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         rr_q    <= rr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      rr_d      = rr_q;
      s_req_o   = 1'b0;
      s_addr_o  = '0;
      s_we_o    = 1'b0;
      s_be_o    = '0;
      s_wdata_o = '0;
      gnt       = 1'b0;
      rv        = 1'b0;
      rdata     = '0;
      err_o     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|m_req_i) begin
               win_d   = pick;
               state_d = REQ;
            end
         end
         REQ: begin
            if (in_win) begin
               s_req_o   = 1'b1;
               s_addr_o  = addr_a[win_q];
               s_we_o    = m_we_i[win_q];
               s_be_o    = be_a[win_q];
               s_wdata_o = wdata_a[win_q];
               if (s_gnt_i) begin
                  gnt     = 1'b1;
                  state_d = RESP;
               end
            end else begin
               gnt     = 1'b1;
               state_d = ERR_RESP;
            end
         end
         RESP: begin
            if (s_rvalid_i) begin
               rv      = 1'b1;
               rdata   = s_rdata_i;
               rr_d    = nxt_ptr;
               state_d = IDLE;
            end
         end
         ERR_RESP: begin
            rv      = 1'b1;
            rdata   = ERR_RDATA;
            err_o   = 1'b1;
            rr_d    = nxt_ptr;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_gnt_o    = '0;
      m_rvalid_o = '0;
      m_rdata_o  = '0;
      for (int i = 0; i < NMASTER; i++) begin
         if (IW'(i) == win_q) begin
            m_gnt_o[i]           = gnt;
            m_rvalid_o[i]        = rv;
            m_rdata_o[i*32 +: 32] = rdata;
         end
      end
   end

endmodule

// File: tb/tb_ext_slow_mem_arbiter.sv
// Randomized bench for ext_slow_mem_arbiter against a transaction-level
// round-robin model; a second instance covers a window ending at 2^32.
module tb_ext_slow_mem_arbiter;

   localparam int          NM    = 3;
   localparam logic [31:0] START = 32'h0000_4000;
   localparam logic [31:0] SZ    = 32'h200;
   localparam logic [31:0] ERRD  = 32'hBADCAB1E;
   localparam logic [31:0] TOPS  = 32'hFFFF_FE00;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NM-1:0]     m_req = '0;
   logic [NM-1:0]     m_gnt;
   logic [NM*32-1:0]  m_addr = '0;
   logic [NM-1:0]     m_we = '0;
   logic [NM*4-1:0]   m_be = '0;
   logic [NM*32-1:0]  m_wdata = '0;
   logic [NM-1:0]     m_rvalid;
   logic [NM*32-1:0]  m_rdata;
   logic              s_req;
   logic              s_gnt = 1'b0;
   logic [31:0]       s_addr;
   logic              s_we;
   logic [3:0]        s_be;
   logic [31:0]       s_wdata;
   logic              s_rvalid = 1'b0;
   logic [31:0]       s_rdata = '0;
   logic              busy;
   logic              err;

   logic [1:0]        m_req2 = '0;
   logic [1:0]        m_gnt2;
   logic [63:0]       m_addr2 = '0;
   logic [1:0]        m_rvalid2;
   logic [63:0]       m_rdata2;
   logic              s_req2;
   logic [31:0]       s_addr2;
   logic              s_we2;
   logic [3:0]        s_be2;
   logic [31:0]       s_wdata2;
   logic              busy2;
   logic              err2;

   int checks = 0;
   int errors = 0;
   int mdl_rr = 0;

   always #5 clk = ~clk;

   ext_slow_mem_arbiter #(
      .NMASTER    (NM),
      .START_ADDR (START),
      .SIZE       (SZ),
      .ERR_RDATA  (ERRD)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .m_req_i    (m_req),
      .m_gnt_o    (m_gnt),
      .m_addr_i   (m_addr),
      .m_we_i     (m_we),
      .m_be_i     (m_be),
      .m_wdata_i  (m_wdata),
      .m_rvalid_o (m_rvalid),
      .m_rdata_o  (m_rdata),
      .s_req_o    (s_req),
      .s_gnt_i    (s_gnt),
      .s_addr_o   (s_addr),
      .s_we_o     (s_we),
      .s_be_o     (s_be),
      .s_wdata_o  (s_wdata),
      .s_rvalid_i (s_rvalid),
      .s_rdata_i  (s_rdata),
      .busy_o     (busy),
      .err_o      (err)
   );

   ext_slow_mem_arbiter #(
      .NMASTER    (2),
      .START_ADDR (TOPS),
      .SIZE       (SZ),
      .ERR_RDATA  (ERRD)
   ) dut2 (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .m_req_i    (m_req2),
      .m_gnt_o    (m_gnt2),
      .m_addr_i   (m_addr2),
      .m_we_i     (2'b00),
      .m_be_i     (8'h00),
      .m_wdata_i  (64'h0),
      .m_rvalid_o (m_rvalid2),
      .m_rdata_o  (m_rdata2),
      .s_req_o    (s_req2),
      .s_gnt_i    (1'b1),
      .s_addr_o   (s_addr2),
      .s_we_o     (s_we2),
      .s_be_o     (s_be2),
      .s_wdata_o  (s_wdata2),
      .s_rvalid_i (1'b1),
      .s_rdata_i  (32'h0),
      .busy_o     (busy2),
      .err_o      (err2)
   );

   function automatic bit in_win(logic [31:0] a, logic [31:0] st,
                                 logic [31:0] sz);
      longint x, lo, hi;
      x  = longint'({32'b0, a});
      lo = longint'({32'b0, st});
      hi = lo + longint'({32'b0, sz});
      return (x >= lo) && (x < hi);
   endfunction

   function automatic int pick(logic [NM-1:0] mask);
      for (int k = 0; k < NM; k++) begin
         if (mask[(mdl_rr + k) % NM]) return (mdl_rr + k) % NM;
      end
      return 0;
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0: return START - 32'd4;
         1: return START + SZ + 32'($urandom_range(0, 15)) * 4;
         2: return $urandom;
         default: return START + 32'($urandom_range(0, 127)) * 4;
      endcase
   endfunction

   // one full transaction, starting one cycle into IDLE
   task automatic do_txn(input logic [NM-1:0] mask, input int gwait,
                         input int rwait, input logic [31:0] rd);
      int w;
      bit iw;
      logic [31:0] a;
      logic [NM-1:0] oh, eg;
      logic [NM*32-1:0] erd;
      logic [70+2*NM:0] rq_got, rq_exp;
      logic [NM*34+2:0] rs_got, rs_exp;
      logic [2*NM+2:0] id_got;
      w  = pick(mask);
      a  = m_addr[w*32 +: 32];
      iw = in_win(a, START, SZ);
      oh = NM'(1) << w;
      m_req    = mask;
      s_gnt    = 1'($urandom_range(0, 1));
      s_rvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
      id_got = {busy, m_gnt, m_rvalid, s_req, err};
      checks++;
      if (id_got !== '0) begin
         errors++;
         $display("FAIL idle: got %h exp 0", id_got);
      end
      @(posedge clk); #1;
      s_gnt = 1'b0;
      if (iw) begin
         for (int k = 0; k <= gwait; k++) begin
            s_gnt    = (k == gwait);
            s_rvalid = 1'($urandom_range(0, 1));
            eg = (k == gwait) ? oh : {NM{1'b0}};
            @(negedge clk);
            rq_got = {s_req, s_addr, s_we, s_be, s_wdata, m_gnt, m_rvalid, busy};
            rq_exp = {1'b1, a, m_we[w], m_be[w*4 +: 4], m_wdata[w*32 +: 32],
                      eg, {NM{1'b0}}, 1'b1};
            checks++;
            if (rq_got !== rq_exp) begin
               errors++;
               $display("FAIL req m%0d k=%0d: got %h exp %h", w, k, rq_got, rq_exp);
            end
            @(posedge clk); #1;
         end
         s_gnt = 1'b0;
         m_req = '0;
         for (int k = 0; k <= rwait; k++) begin
            s_rvalid = (k == rwait);
            s_rdata  = (k == rwait) ? rd : $urandom;
            s_gnt    = 1'($urandom_range(0, 1));
            erd = '0;
            if (k == rwait) erd[w*32 +: 32] = rd;
            eg = (k == rwait) ? oh : {NM{1'b0}};
            @(negedge clk);
            rs_got = {m_rvalid, m_rdata, m_gnt, s_req, err, busy};
            rs_exp = {eg, erd, {NM{1'b0}}, 1'b0, 1'b0, 1'b1};
            checks++;
            if (rs_got !== rs_exp) begin
               errors++;
               $display("FAIL resp m%0d k=%0d: got %h exp %h", w, k, rs_got, rs_exp);
            end
            @(posedge clk); #1;
         end
      end else begin
         @(negedge clk);
         rq_got = {s_req, s_addr, s_we, s_be, s_wdata, m_gnt, m_rvalid, busy};
         rq_exp = {1'b0, 32'h0, 1'b0, 4'h0, 32'h0, oh, {NM{1'b0}}, 1'b1};
         checks++;
         if (rq_got !== rq_exp) begin
            errors++;
            $display("FAIL err_req m%0d: got %h exp %h", w, rq_got, rq_exp);
         end
         @(posedge clk); #1;
         m_req    = '0;
         s_rvalid = 1'($urandom_range(0, 1));
         s_rdata  = $urandom;
         erd = '0;
         erd[w*32 +: 32] = ERRD;
         @(negedge clk);
         rs_got = {m_rvalid, m_rdata, m_gnt, s_req, err, busy};
         rs_exp = {oh, erd, {NM{1'b0}}, 1'b0, 1'b1, 1'b1};
         checks++;
         if (rs_got !== rs_exp) begin
            errors++;
            $display("FAIL err_resp m%0d: got %h exp %h", w, rs_got, rs_exp);
         end
         @(posedge clk); #1;
      end
      s_rvalid = 1'b0;
      s_gnt    = 1'b0;
      mdl_rr   = (w + 1) % NM;
   endtask

   task automatic test_reset();
      m_req = '1;
      s_gnt = 1'b1;
      s_rvalid = 1'b1;
      s_rdata = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({m_gnt, m_rvalid, m_rdata, s_req, s_addr, s_we, s_be, s_wdata, busy, err} !== '0) begin
         errors++;
         $display("FAIL reset_hold: got %h exp 0",
                  {m_gnt, m_rvalid, m_rdata, s_req, s_addr, s_we, s_be, s_wdata, busy, err});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_req = '0;
      s_gnt = 1'b0;
      s_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if ({m_gnt, m_rvalid, m_rdata, s_req, s_addr, busy, err} !== '0) begin
         errors++;
         $display("FAIL reset_release: got %h exp 0",
                  {m_gnt, m_rvalid, m_rdata, s_req, s_addr, busy, err});
      end
      @(posedge clk); #1;
      mdl_rr = 0;
   endtask

   task automatic test_alternate();
      for (int i = 0; i < NM; i++) m_addr[i*32 +: 32] = START + 32'(i * 16);
      for (int i = 0; i < 4; i++) do_txn(3'b011, 0, 0, $urandom);
   endtask

   task automatic test_single_read();
      m_addr[0 +: 32] = START + 32'd4;
      m_we[0] = 1'b0;
      m_be[0 +: 4] = 4'hF;
      do_txn(3'b001, 0, 1, 32'h12345678);
   endtask

   task automatic test_out_of_window();
      m_addr[32 +: 32] = START + 32'h200;
      do_txn(3'b010, 0, 0, $urandom);
      m_addr[64 +: 32] = START - 32'd4;
      do_txn(3'b100, 0, 0, $urandom);
   endtask

   task automatic test_gnt_stall();
      m_addr[64 +: 32] = START + SZ - 32'd4;
      m_we[2] = 1'b1;
      m_be[8 +: 4] = 4'h5;
      m_wdata[64 +: 32] = 32'hCAFE_F00D;
      do_txn(3'b100, 5, 0, $urandom);
   endtask

   task automatic test_random();
      logic [NM-1:0] mask;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < NM; i++) begin
            m_addr[i*32 +: 32]  = rand_addr();
            m_we[i]             = 1'($urandom_range(0, 1));
            m_be[i*4 +: 4]      = 4'($urandom_range(0, 15));
            m_wdata[i*32 +: 32] = $urandom;
         end
         mask = NM'($urandom_range(1, (1 << NM) - 1));
         do_txn(mask, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < NM; i++) m_addr[i*32 +: 32] = START + 32'(i * 8);
      do_txn(3'b001, 0, 0, $urandom);
      m_req = 3'b010;
      @(posedge clk); #1;
      s_gnt = 1'b1;
      @(posedge clk); #1;
      s_gnt = 1'b0;
      m_req = '0;
      @(negedge clk);
      checks++;
      if ({busy, m_rvalid} !== {1'b1, {NM{1'b0}}}) begin
         errors++;
         $display("FAIL mid_in_resp: got %b exp %b", {busy, m_rvalid}, {1'b1, {NM{1'b0}}});
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({m_gnt, m_rvalid, m_rdata, s_req, s_addr, s_we, s_be, s_wdata, busy, err} !== '0) begin
         errors++;
         $display("FAIL mid_async_reset: got %h exp 0",
                  {m_gnt, m_rvalid, m_rdata, s_req, s_addr, s_we, s_be, s_wdata, busy, err});
      end
      s_rvalid = 1'b1;
      s_rdata  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({m_gnt, m_rvalid, m_rdata, busy, err} !== '0) begin
         errors++;
         $display("FAIL mid_late_rvalid: got %h exp 0", {m_gnt, m_rvalid, m_rdata, busy, err});
      end
      @(posedge clk); #1;
      s_rvalid = 1'b0;
      mdl_rr = 0;
      do_txn(3'b111, 0, 0, $urandom);
   endtask

   task automatic test_top_window();
      logic [31:0] al [4];
      bit e;
      al[0] = 32'hFFFF_FFFC;
      al[1] = TOPS;
      al[2] = TOPS - 32'd4;
      al[3] = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
         m_req2 = 2'b01;
         m_addr2[31:0] = al[i];
         e = in_win(al[i], TOPS, SZ);
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if ({s_req2, m_gnt2} !== {e, 2'b01}) begin
            errors++;
            $display("FAIL top_window %h: got %b exp %b", al[i], {s_req2, m_gnt2}, {e, 2'b01});
         end
         @(posedge clk); #1;
         m_req2 = 2'b00;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_single_read();
      test_out_of_window();
      test_gnt_stall();
      test_random();
      test_reset_mid();
      test_top_window();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ext_slow_mem_arbiter.md
EXT_SLOW_MEM_ARBITER -- requirements
Module: ext_slow_mem_arbiter

Interface
REQ-001 Parameter NMASTER, default 2, number of OBI masters sharing the slow memory (range 2..8).
REQ-002 Parameter START_ADDR, default core_v_mini_mcu_pkg::EXT_SLAVE_START_ADDRESS, first byte of the slow-memory window.
REQ-003 Parameter SIZE, default 32'h200, window size in bytes; the window is START_ADDR <= addr < START_ADDR+SIZE.
REQ-004 Parameter ERR_RDATA, default 32'hBADCAB1E, read data returned for out-of-window accesses.
REQ-005 The port list SHALL be exactly the following; clock is single, reset is asynchronous and active-low:
  clk_i  in  1  clock
  rst_ni  in  1  asynchronous active-low reset
  m_req_i  in  NMASTER  per-master OBI request
  m_gnt_o  out  NMASTER  per-master OBI grant
  m_addr_i  in  NMASTER*32  per-master address
  m_we_i  in  NMASTER  per-master write enable
  m_be_i  in  NMASTER*4  per-master byte enables
  m_wdata_i  in  NMASTER*32  per-master write data
  m_rvalid_o  out  NMASTER  per-master response valid
  m_rdata_o  out  NMASTER*32  per-master read data
  s_req_o  out  1  slave request
  s_gnt_i  in  1  slave grant
  s_addr_o  out  32  slave address
  s_we_o  out  1  slave write enable
  s_be_o  out  4  slave byte enables
  s_wdata_o  out  32  slave write data
  s_rvalid_i  in  1  slave response valid
  s_rdata_i  in  32  slave read data
  busy_o  out  1  high whenever FSM is not IDLE
  err_o  out  1  one-cycle pulse on out-of-window response

Function
REQ-006 FSM states: IDLE, REQ, RESP, ERR_RESP; at most one transaction in flight at any time.
REQ-007 IDLE: if any m_req_i bit is high, the winner SHALL be the first requesting index at or after rr_ptr, wrapping modulo NMASTER; latch it in win_q; go to REQ. If none, stay.
REQ-008 REQ with m_addr_i[win_q] in window: s_req_o=1 and s_addr/we/be/wdata muxed from win_q; on s_gnt_i, m_gnt_o[win_q]=1 in that same cycle, then go to RESP.
REQ-009 REQ with address out of window: s_req_o=0, m_gnt_o[win_q]=1 for one cycle, then go to ERR_RESP.
REQ-010 RESP: on s_rvalid_i, m_rvalid_o[win_q]=1 and m_rdata_o[win_q]=s_rdata_i in that same cycle; set rr_ptr=(win_q+1) mod NMASTER; go to IDLE.
REQ-011 ERR_RESP: m_rvalid_o[win_q]=1, m_rdata_o[win_q]=ERR_RDATA, err_o=1 for one cycle; rr_ptr=(win_q+1) mod NMASTER; go to IDLE.
REQ-012 Minimum latency: request at cycle 0, grant at cycle 1 (zero-wait slave), rvalid no earlier than cycle 2; back-to-back transactions spaced by at least one IDLE cycle.
REQ-013 Non-winning masters SHALL see m_gnt_o=0 and m_rvalid_o=0; m_rdata_o of non-selected masters SHALL be 0.
REQ-014 s_rvalid_i outside RESP and s_gnt_i outside REQ SHALL be ignored.
REQ-015 Window comparison uses 33-bit arithmetic so that START_ADDR+SIZE = 2^32 does not wrap.
REQ-016 Masters hold request fields stable until granted (OBI rule); the arbiter does not re-arbitrate while in REQ.

Reset
REQ-017 On rst_ni low (asynchronous): state=IDLE, win_q=0, rr_ptr=0, and all outputs 0 (m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o, busy_o, err_o).
REQ-018 Reset asserted mid-transaction abandons it; a late s_rvalid_i after reset release SHALL NOT be forwarded.

Verification
REQ-019 Master0 read of START_ADDR+4, slave gnt same cycle, rvalid 2 cycles later with 32'h12345678 -> m_gnt_o=01 at cycle 1, m_rvalid_o=01 with 32'h12345678, busy_o high throughout.
REQ-020 Both masters request continuously from reset -> grants alternate 0,1,0,1; no master granted twice in a row.
REQ-021 Master1 reads START_ADDR+32'h200 -> no s_req_o, m_gnt_o=10, next cycle m_rvalid_o=10 with 32'hBADCAB1E and err_o pulse.
REQ-022 Slave holds s_gnt_i low for 5 cycles -> s_req_o and its fields stay stable, no m_gnt_o until s_gnt_i rises.
REQ-023 rst_ni pulsed low while in RESP, s_rvalid_i arrives afterwards -> all outputs 0, no m_rvalid_o, next arbitration starts at master0.
